// File: rtl/tlul_host_adapter.sv
// Minimal TL-UL type package plus a req/gnt/rvalid host-port adapter that drives one
// TL-UL host channel, with tag generation, in-flight tracking and response checking.
package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_adapter
    import tlul_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int SrcIdW         = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        idle_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam int                CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0]   MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [SrcIdW-1:0] TagLast = SrcIdW'(MaxOutstanding - 1);

    logic [CntW-1:0]   out_cnt_q, out_cnt_d;
    logic [SrcIdW-1:0] tag_q, tag_d;
    logic [SrcIdW-1:0] exp_tag_q, exp_tag_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic a_valid;
    logic gnt;
    logic d_fire;
    logic cnt_zero;
    logic d_accept;
    logic src_mismatch;

    // Tags wrap at MaxOutstanding rather than 2**SrcIdW so in-flight tags stay unique.
    function automatic logic [SrcIdW-1:0] next_tag(input logic [SrcIdW-1:0] t);
        return (t == TagLast) ? '0 : t + 1'b1;
    endfunction

    assign cnt_zero     = (out_cnt_q == '0);
    assign a_valid      = rst_ni & req_i & (out_cnt_q < MaxCnt);
    assign gnt          = a_valid & tl_i.a_ready;
    assign d_fire       = rst_ni & tl_i.d_valid;
    assign d_accept     = d_fire & ~cnt_zero;
    assign src_mismatch = (tl_i.d_source != TL_AIW'(exp_tag_q));

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = TL_AIW'(tag_q);
        tl_o.a_address = {addr_i[31:2], 2'b00};
        tl_o.a_data    = wdata_i;
        tl_o.d_ready   = rst_ni;
        if (!we_i) begin
            tl_o.a_opcode = Get;
            tl_o.a_mask   = 4'hF;
        end else if (be_i == 4'hF) begin
            tl_o.a_opcode = PutFullData;
            tl_o.a_mask   = be_i;
        end else begin
            tl_o.a_opcode = PutPartialData;
            tl_o.a_mask   = be_i;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (gnt && !d_accept) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (d_accept && !gnt) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end

        tag_d     = gnt ? next_tag(tag_q) : tag_q;
        exp_tag_d = d_accept ? next_tag(exp_tag_q) : exp_tag_q;

        rvalid_d = d_fire;
        err_d    = d_fire & (tl_i.d_error | src_mismatch | cnt_zero);
        rdata_d  = rdata_q;
        if (d_fire) begin
            rdata_d = (tl_i.d_opcode == AccessAck) ? 32'h0 : tl_i.d_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
            tag_q     <= '0;
            exp_tag_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            tag_q     <= tag_d;
            exp_tag_q <= exp_tag_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign idle_o   = ~rst_ni | cnt_zero;

    // Response fields this adapter has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter: reads, writes, full stall, simultaneous
// grant/response, error cases and reset with transactions in flight.
module tb_tlul_host_adapter;
    import tlul_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = 4'hF;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        idle_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    int checks = 0;
    int fails  = 0;

    tlul_host_adapter #(.MaxOutstanding(2), .SrcIdW(2)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .idle_o  (idle_o),
        .tl_o    (tl_o),
        .tl_i    (tl_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0;
        we_i = 1'b0;
        be_i = 4'hF;
        addr_i = '0;
        wdata_i = '0;
        tl_i.d_valid = 1'b0;
        tl_i.d_error = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [31:0] data,
                           input logic [7:0] src, input logic derr);
        tl_i.d_valid = 1'b1;
        tl_i.d_opcode = tl_d_op_e'(op);
        tl_i.d_data = data;
        tl_i.d_source = src;
        tl_i.d_error = derr;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        req_i = 1'b1;
        #1;
        checks++; if (gnt_o !== 1'b0) begin fails++; $display("FAIL rst_gnt: got %0b want 0", gnt_o); end
        checks++; if (tl_o.a_valid !== 1'b0) begin fails++; $display("FAIL rst_avalid: got %0b want 0", tl_o.a_valid); end
        checks++; if (tl_o.d_ready !== 1'b0) begin fails++; $display("FAIL rst_dready: got %0b want 0", tl_o.d_ready); end
        step();
        step();
        checks++; if (idle_o !== 1'b1) begin fails++; $display("FAIL rst_idle: got %0b want 1", idle_o); end
        checks++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %0b want 0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", err_o); end
        req_i = 1'b0;
        rst_ni = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_read();
        do_reset();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1004;
        #1;
        checks++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL rd_gnt: got %0b want 1", gnt_o); end
        checks++; if (tl_o.a_opcode !== Get) begin fails++; $display("FAIL rd_opcode: got %0d want 4", tl_o.a_opcode); end
        checks++; if (tl_o.a_source !== 8'd0) begin fails++; $display("FAIL rd_source: got %0d want 0", tl_o.a_source); end
        checks++; if (tl_o.a_address !== 32'h1004) begin fails++; $display("FAIL rd_addr: got %h want 1004", tl_o.a_address); end
        checks++; if (tl_o.a_mask !== 4'hF) begin fails++; $display("FAIL rd_mask: got %h want f", tl_o.a_mask); end
        checks++; if (tl_o.a_size !== 2'd2) begin fails++; $display("FAIL rd_size: got %0d want 2", tl_o.a_size); end
        step();
        req_i = 1'b0;
        checks++; if (idle_o !== 1'b0) begin fails++; $display("FAIL rd_busy: got %0b want 0", idle_o); end
        drive_d(3'd1, 32'hCAFEF00D, 8'd0, 1'b0);
        #1;
        checks++; if (tl_o.d_ready !== 1'b1) begin fails++; $display("FAIL rd_dready: got %0b want 1", tl_o.d_ready); end
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1) begin fails++; $display("FAIL rd_rvalid: got %0b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'hCAFEF00D) begin fails++; $display("FAIL rd_rdata: got %h want cafef00d", rdata_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL rd_err: got %0b want 0", err_o); end
        checks++; if (idle_o !== 1'b1) begin fails++; $display("FAIL rd_idle: got %0b want 1", idle_o); end
        step();
        checks++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rd_rvalid_drop: got %0b want 0", rvalid_o); end
        $display("test_read done");
    endtask

    task automatic test_write();
        do_reset();
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h2000; wdata_i = 32'h11223344;
        #1;
        checks++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL wr_gnt: got %0b want 1", gnt_o); end
        checks++; if (tl_o.a_opcode !== PutFullData) begin fails++; $display("FAIL wr_full_op: got %0d want 0", tl_o.a_opcode); end
        checks++; if (tl_o.a_data !== 32'h11223344) begin fails++; $display("FAIL wr_data: got %h want 11223344", tl_o.a_data); end
        step();
        req_i = 1'b0;
        drive_d(3'd0, 32'h12345678, 8'd0, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1) begin fails++; $display("FAIL wr_rvalid: got %0b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL wr_rdata_zero: got %h want 0", rdata_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL wr_err: got %0b want 0", err_o); end
        req_i = 1'b1; we_i = 1'b1; be_i = 4'h3; addr_i = 32'h1003;
        #1;
        checks++; if (tl_o.a_opcode !== PutPartialData) begin fails++; $display("FAIL wr_part_op: got %0d want 1", tl_o.a_opcode); end
        checks++; if (tl_o.a_mask !== 4'h3) begin fails++; $display("FAIL wr_part_mask: got %h want 3", tl_o.a_mask); end
        checks++; if (tl_o.a_address !== 32'h1000) begin fails++; $display("FAIL wr_align: got %h want 1000", tl_o.a_address); end
        checks++; if (tl_o.a_source !== 8'd1) begin fails++; $display("FAIL wr_source: got %0d want 1", tl_o.a_source); end
        step();
        req_i = 1'b0;
        drive_d(3'd0, 32'h0, 8'd1, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL wr_part_err: got %0b want 0", err_o); end
        checks++; if (idle_o !== 1'b1) begin fails++; $display("FAIL wr_idle: got %0b want 1", idle_o); end
        $display("test_write done");
    endtask

    task automatic test_full();
        do_reset();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        #1;
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin fails++; $display("FAIL full_g0: got gnt=%0b src=%0d want 1/0", gnt_o, tl_o.a_source); end
        step();
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd1) begin fails++; $display("FAIL full_g1: got gnt=%0b src=%0d want 1/1", gnt_o, tl_o.a_source); end
        step();
        checks++; if (gnt_o !== 1'b0 || tl_o.a_valid !== 1'b0) begin fails++; $display("FAIL full_stall: got gnt=%0b av=%0b want 0/0", gnt_o, tl_o.a_valid); end
        drive_d(3'd1, 32'hA5A5A5A5, 8'd0, 1'b0);
        #1;
        checks++; if (gnt_o !== 1'b0) begin fails++; $display("FAIL full_dfire_nogrant: got %0b want 0", gnt_o); end
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b0) begin fails++; $display("FAIL full_resp: got rv=%0b err=%0b want 1/0", rvalid_o, err_o); end
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin fails++; $display("FAIL full_g2: got gnt=%0b src=%0d want 1/0", gnt_o, tl_o.a_source); end
        step();
        req_i = 1'b0;
        drive_d(3'd1, 32'h1, 8'd1, 1'b0);
        step();
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL full_drain1: got err=%0b want 0", err_o); end
        drive_d(3'd1, 32'h2, 8'd0, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (err_o !== 1'b0 || idle_o !== 1'b1) begin fails++; $display("FAIL full_drain2: got err=%0b idle=%0b want 0/1", err_o, idle_o); end
        $display("test_full done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h80;
        step();
        drive_d(3'd1, 32'h0BADBEEF, 8'd0, 1'b0);
        #1;
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd1) begin fails++; $display("FAIL b2b_gnt: got gnt=%0b src=%0d want 1/1", gnt_o, tl_o.a_source); end
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'h0BADBEEF) begin fails++; $display("FAIL b2b_resp: got rv=%0b err=%0b data=%h want 1/0/0badbeef", rvalid_o, err_o, rdata_o); end
        checks++; if (idle_o !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %0b want 0", idle_o); end
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin fails++; $display("FAIL b2b_cnt1: got gnt=%0b src=%0d want 1/0", gnt_o, tl_o.a_source); end
        step();
        checks++; if (gnt_o !== 1'b0) begin fails++; $display("FAIL b2b_full: got %0b want 0", gnt_o); end
        req_i = 1'b0;
        drive_d(3'd1, 32'h3, 8'd1, 1'b0);
        step();
        drive_d(3'd1, 32'h4, 8'd0, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (err_o !== 1'b0 || idle_o !== 1'b1) begin fails++; $display("FAIL b2b_drain: got err=%0b idle=%0b want 0/1", err_o, idle_o); end
        $display("test_back_to_back done");
    endtask

    task automatic test_errors();
        do_reset();
        drive_d(3'd1, 32'h55, 8'd0, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || idle_o !== 1'b1) begin fails++; $display("FAIL err_unexp: got rv=%0b err=%0b idle=%0b want 1/1/1", rvalid_o, err_o, idle_o); end
        req_i = 1'b1; we_i = 1'b0;
        #1;
        checks++; if (tl_o.a_source !== 8'd0) begin fails++; $display("FAIL err_tag_hold: got %0d want 0", tl_o.a_source); end
        step();
        req_i = 1'b0;
        drive_d(3'd1, 32'h66, 8'd1, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin fails++; $display("FAIL err_src: got rv=%0b err=%0b want 1/1", rvalid_o, err_o); end
        req_i = 1'b1;
        #1;
        checks++; if (tl_o.a_source !== 8'd1) begin fails++; $display("FAIL err_src2: got %0d want 1", tl_o.a_source); end
        step();
        req_i = 1'b0;
        drive_d(3'd1, 32'h77, 8'd1, 1'b1);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (err_o !== 1'b1 || rdata_o !== 32'h77) begin fails++; $display("FAIL err_derror: got err=%0b data=%h want 1/77", err_o, rdata_o); end
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        drive_d(3'd1, 32'h88, 8'd0, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (err_o !== 1'b0 || rdata_o !== 32'h88) begin fails++; $display("FAIL err_wrap_ok: got err=%0b data=%h want 0/88", err_o, rdata_o); end
        $display("test_errors done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i = 1'b1; we_i = 1'b0;
        step();
        step();
        req_i = 1'b0;
        checks++; if (idle_o !== 1'b0) begin fails++; $display("FAIL rm_busy: got %0b want 0", idle_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (idle_o !== 1'b1 || tl_o.d_ready !== 1'b0) begin fails++; $display("FAIL rm_in_reset: got idle=%0b dr=%0b want 1/0", idle_o, tl_o.d_ready); end
        step();
        step();
        rst_ni = 1'b1;
        #1;
        checks++; if (idle_o !== 1'b1 || rvalid_o !== 1'b0) begin fails++; $display("FAIL rm_after: got idle=%0b rv=%0b want 1/0", idle_o, rvalid_o); end
        drive_d(3'd1, 32'h99, 8'd1, 1'b0);
        step();
        tl_i.d_valid = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin fails++; $display("FAIL rm_stale_d: got rv=%0b err=%0b want 1/1", rvalid_o, err_o); end
        req_i = 1'b1;
        #1;
        checks++; if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin fails++; $display("FAIL rm_tag0: got gnt=%0b src=%0d want 1/0", gnt_o, tl_o.a_source); end
        step();
        req_i = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        tl_i = '0;
        tl_i.a_ready = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_full();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
